// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: state codes and handshake levels.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock.
// result_o = {remainder, quotient}; ready_o is high only while the unit sits in END.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  // Two's complement negation, truncated to the operand width.
  function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  div_state_t              state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [2*DATA_W-1:0]     sr_r;        // {partial remainder, dividend/quotient bits}
  logic [DATA_W-1:0]       divisor_r;
  logic                    q_neg_r;
  logic                    r_neg_r;

  logic [DATA_W-1:0]       abs1_s;
  logic [DATA_W-1:0]       abs2_s;
  logic [2*DATA_W:0]       shift_s;     // shift register moved left by one, carry bit on top
  logic [DATA_W:0]         diff_s;
  logic [2*DATA_W-1:0]     sr_next_s;
  logic [DATA_W-1:0]       quot_fix_s;
  logic [DATA_W-1:0]       rem_fix_s;

  // Operand magnitudes; a signed most-negative value maps onto itself as an unsigned magnitude.
  always_comb begin
    abs1_s = opdata1_i;
    abs2_s = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) begin
      abs1_s = neg2(opdata1_i);
    end else begin
      abs1_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[DATA_W-1]) begin
      abs2_s = neg2(opdata2_i);
    end else begin
      abs2_s = opdata2_i;
    end
  end

  // One restoring step: shift, trial-subtract, keep the difference when it does not borrow.
  always_comb begin
    shift_s   = {sr_r, 1'b0};
    diff_s    = shift_s[2*DATA_W:DATA_W] - {1'b0, divisor_r};
    sr_next_s = shift_s[2*DATA_W-1:0];
    if (!diff_s[DATA_W]) begin
      sr_next_s = {diff_s[DATA_W-1:0], shift_s[DATA_W-1:1], 1'b1};
    end else begin
      sr_next_s = shift_s[2*DATA_W-1:0];
    end
  end

  // Sign fixup: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    quot_fix_s = sr_r[DATA_W-1:0];
    rem_fix_s  = sr_r[2*DATA_W-1:DATA_W];
    if (q_neg_r) begin
      quot_fix_s = neg2(sr_r[DATA_W-1:0]);
    end else begin
      quot_fix_s = sr_r[DATA_W-1:0];
    end
    if (r_neg_r) begin
      rem_fix_s = neg2(sr_r[2*DATA_W-1:DATA_W]);
    end else begin
      rem_fix_s = sr_r[2*DATA_W-1:DATA_W];
    end
  end

  // Control FSM with registered result/ready; reset wins over every input in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= DIV_FREE;
      cnt_r     <= '0;
      sr_r      <= '0;
      divisor_r <= '0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_r)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state_r <= DIV_BYZERO;
            end else begin
              state_r   <= DIV_ON;
              cnt_r     <= '0;
              sr_r      <= {{DATA_W{1'b0}}, abs1_s};
              divisor_r <= abs2_s;
              q_neg_r   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg_r   <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i || start_i == DIV_STOP) begin
            state_r <= DIV_FREE;
          end else begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_READY;
            state_r  <= DIV_END;
          end
        end
        DIV_ON: begin
          if (annul_i || start_i == DIV_STOP) begin
            state_r <= DIV_FREE;
          end else if (cnt_r == CNT_LAST) begin
            result_o <= {rem_fix_s, quot_fix_s};
            ready_o  <= DIV_RESULT_READY;
            state_r  <= DIV_END;
          end else begin
            sr_r  <= sr_next_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_r  <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end
        end
        default: begin
          state_r  <= DIV_FREE;
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized ops against a
// plain-arithmetic reference model (signed / and % on 64-bit integers).
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_cmp;
  int n_fail;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient}, truncated to 32 bits; zero divisor gives 0.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] b);
    return (b == 32'd0) ? 2 : 34;
  endfunction

  // Raise a request and wait (bounded) for ready; cyc counts negedges from the request.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output logic [63:0] res, output int cyc);
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (scramble && !ready) begin
        op1 = $urandom;
        op2 = $urandom;
      end
    end while (!ready && cyc < 100);
    res = result;
  endtask

  task automatic release_op;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = 32'd0; op2 = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: ready=%b result=%h, want 0/0", ready, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    logic [63:0] res;
    int cyc;
    run_op(1'b0, 32'd100, 32'd7, 1'b0, res, cyc);
    n_cmp++;
    if (cyc !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d want 34", cyc); end
    n_cmp++;
    if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14}); end
    // start held high through END must hold the result and not retrigger
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL end_hold: ready=%b result=%h want 1/%h", ready, result, {32'd2, 32'd14});
    end
    release_op();
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++; $display("FAIL end_release: ready=%b result=%h want 0/0", ready, result);
    end
  endtask

  task automatic test_signed;
    logic [31:0] a_tab [4] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] b_tab [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [63:0] w_tab [4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h00000001, 32'hFFFFFFFD},
                               {32'hFFFFFFFF, 32'h00000003}, {32'h00000000, 32'h80000000}};
    logic [63:0] res;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, a_tab[i], b_tab[i], 1'b0, res, cyc);
      n_cmp++;
      if (res !== w_tab[i] || cyc !== 34) begin
        n_fail++;
        $display("FAIL signed_%0d: got %h in %0d cycles want %h in 34", i, res, cyc, w_tab[i]);
      end
      release_op();
    end
  endtask

  task automatic test_divzero;
    logic [63:0] res;
    int cyc;
    run_op(1'b1, 32'd5, 32'd0, 1'b0, res, cyc);
    n_cmp++;
    if (cyc !== 2 || res !== 64'd0) begin
      n_fail++; $display("FAIL div_by_zero: got %h in %0d cycles want 0 in 2", res, cyc);
    end
    release_op();
  endtask

  task automatic test_annul;
    logic [63:0] res;
    int cyc;
    int seen;
    signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd11; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL annul_no_ready: ready high %0d cycles want 0", seen); end
    run_op(1'b0, 32'd9, 32'd3, 1'b0, res, cyc);
    n_cmp++;
    if (res !== {32'd0, 32'd3} || cyc !== 34) begin
      n_fail++; $display("FAIL after_annul: got %h in %0d cycles want %h in 34", res, cyc, {32'd0, 32'd3});
    end
    release_op();
  endtask

  task automatic test_rst_mid;
    logic [63:0] res;
    int cyc;
    int seen;
    signed_div = 1'b0; op1 = 32'd5000; op2 = 32'd3; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready || result !== 64'd0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_in_on: nonzero outputs %0d cycles want 0", seen); end
    // reset while in END
    run_op(1'b0, 32'd77, 32'd5, 1'b0, res, cyc);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++; $display("FAIL rst_in_end: ready=%b result=%h want 0/0", ready, result);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operand_change;
    logic [63:0] res;
    int cyc;
    run_op(1'b0, 32'd1000, 32'd10, 1'b1, res, cyc);
    n_cmp++;
    if (res !== {32'd0, 32'd100} || cyc !== 34) begin
      n_fail++; $display("FAIL operand_change: got %h in %0d cycles want %h in 34", res, cyc, {32'd0, 32'd100});
    end
    release_op();
  endtask

  task automatic test_back_to_back;
    logic [63:0] res;
    int cyc;
    run_op(1'b1, 32'hFFFFFF00, 32'd16, 1'b0, res, cyc);
    start = 1'b0;
    @(negedge clk);
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, 1'b0, res, cyc);
    n_cmp++;
    if (res !== model(1'b0, 32'hFFFFFFFF, 32'd2) || cyc !== 34) begin
      n_fail++; $display("FAIL back_to_back: got %h in %0d cycles want %h in 34", res, cyc, model(1'b0, 32'hFFFFFFFF, 32'd2));
    end
    release_op();
  endtask

  task automatic test_random;
    logic [63:0] res;
    logic [31:0] a, b;
    bit sgn;
    int cyc;
    int sel;
    for (int i = 0; i < 1200; i++) begin
      sgn = $urandom_range(1, 0);
      a = $urandom;
      sel = $urandom_range(7, 0);
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(15, 1);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = 32'hFFFFFFFF - $urandom_range(3, 0);
        4: b = a >> $urandom_range(31, 0);
        default: b = $urandom;
      endcase
      run_op(sgn, a, b, 1'b0, res, cyc);
      n_cmp++;
      if (res !== model(sgn, a, b) || cyc !== model_lat(b)) begin
        n_fail++;
        $display("FAIL random_%0d: s=%0d %h/%h got %h in %0d want %h in %0d",
                 i, sgn, a, b, res, cyc, model(sgn, a, b), model_lat(b));
      end
      release_op();
      n_cmp++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL random_release_%0d: ready=%b want 0", i, ready); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_divzero();
    test_annul();
    test_rst_mid();
    test_operand_change();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
